// File: rtl/lcd_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lcd_bus_arbiter
// Purpose  : Shares the 8-bit 8080-style ILI9341 write bus between a
//            command/parameter port and a 16-bit RGB565 pixel stream port.
//            Generates WR/RS/CS timing and can hold pixel frames until a
//            rising tearing-effect (FMARK) edge.
// Ports    : i_clk, i_reset_n           clock, async active-low reset
//            i_cmd_valid/_data/_last    command byte stream ([8]=RS)
//            o_cmd_ready                command byte accepted on valid&ready
//            i_pix_valid/_data/_last    pixel stream, MSB byte sent first
//            o_pix_ready                pixel accepted on valid&ready
//            i_lcd_fmark                panel TE output (asynchronous)
//            o_lcd_data/_rs/_wr/_cs_n   panel bus pins
//            o_owner                    0 idle, 1 cmd, 2 pixel wait-TE, 3 pixel
// Revision : 1.0  initial release
// ============================================================================
module lcd_bus_arbiter #(
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2,
    parameter int FMARK_SYNC  = 1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [8:0]  i_cmd_data,
    input  logic        i_cmd_last,
    input  logic        i_pix_valid,
    output logic        o_pix_ready,
    input  logic [15:0] i_pix_data,
    input  logic        i_pix_last,
    input  logic        i_lcd_fmark,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_wr,
    output logic        o_lcd_cs_n,
    output logic [1:0]  o_owner
);

    localparam int c_MAXC = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
    localparam int c_CW   = (c_MAXC > 1) ? $clog2(c_MAXC) : 1;
    localparam logic [c_CW-1:0] c_LOW_LOAD  = c_CW'(WR_LOW_CYC - 1);
    localparam logic [c_CW-1:0] c_HIGH_LOAD = c_CW'(WR_HIGH_CYC - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);

    // Owner state encoding doubles as the o_owner value
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CMD  = 2'd1;
    localparam logic [1:0] c_ST_PIXW = 2'd2;
    localparam logic [1:0] c_ST_PIX  = 2'd3;

    localparam logic [1:0] c_ENG_IDLE = 2'd0;
    localparam logic [1:0] c_ENG_LOW  = 2'd1;
    localparam logic [1:0] c_ENG_HIGH = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [1:0]      eng_q, eng_d;
    logic [c_CW-1:0] cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic            rs_q, rs_d;
    logic [7:0]      data_q, data_d;
    logic [7:0]      lo_byte_q, lo_byte_d;
    logic            lo_pend_q, lo_pend_d;
    logic            last_q, last_d;
    logic            fm_s1_q, fm_s2_q, fm_s3_q;

    logic w_cmd_acc;
    logic w_pix_acc;
    logic w_fm_rise;
    logic w_xfer_done;

    assign w_cmd_acc = i_cmd_valid & o_cmd_ready;
    assign w_pix_acc = i_pix_valid & o_pix_ready;
    assign w_fm_rise = fm_s2_q & ~fm_s3_q;
    // Final high-phase cycle of a byte with no pixel low byte still to send
    assign w_xfer_done = (eng_q == c_ENG_HIGH) && (cnt_q == '0) && !lo_pend_q;

    // FMARK synchroniser plus edge-detect history
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            fm_s1_q <= 1'b0;
            fm_s2_q <= 1'b0;
            fm_s3_q <= 1'b0;
        end else begin
            fm_s1_q <= i_lcd_fmark;
            fm_s2_q <= fm_s1_q;
            fm_s3_q <= fm_s2_q;
        end
    end

    // Owner FSM: state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Owner FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (i_cmd_valid) begin
                    state_d = c_ST_CMD;
                end else if (i_pix_valid) begin
                    state_d = (FMARK_SYNC != 0) ? c_ST_PIXW : c_ST_PIX;
                end
            end
            c_ST_PIXW: begin
                if (w_fm_rise) begin
                    state_d = c_ST_PIX;
                end
            end
            c_ST_CMD, c_ST_PIX: begin
                if (w_xfer_done && last_q) begin
                    state_d = c_ST_IDLE;
                end
            end
            default: state_d = c_ST_IDLE;
        endcase
    end

    // Owner FSM: outputs
    always_comb begin
        o_cmd_ready = (state_q == c_ST_CMD) && (eng_q == c_ENG_IDLE);
        o_pix_ready = (state_q == c_ST_PIX) && (eng_q == c_ENG_IDLE);
        o_lcd_cs_n  = !((state_q == c_ST_CMD) || (state_q == c_ST_PIX));
        o_owner     = state_q;
    end

    // Byte engine: next state. Data/RS change only when a new byte starts,
    // so they stay stable through both WR phases and hold in IDLE.
    always_comb begin
        eng_d     = eng_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        rs_d      = rs_q;
        data_d    = data_q;
        lo_byte_d = lo_byte_q;
        lo_pend_d = lo_pend_q;
        last_d    = last_q;
        case (eng_q)
            c_ENG_IDLE: begin
                if (w_cmd_acc) begin
                    data_d    = i_cmd_data[7:0];
                    rs_d      = i_cmd_data[8];
                    last_d    = i_cmd_last;
                    lo_pend_d = 1'b0;
                    wr_d      = 1'b0;
                    cnt_d     = c_LOW_LOAD;
                    eng_d     = c_ENG_LOW;
                end else if (w_pix_acc) begin
                    data_d    = i_pix_data[15:8];
                    lo_byte_d = i_pix_data[7:0];
                    rs_d      = 1'b1;
                    last_d    = i_pix_last;
                    lo_pend_d = 1'b1;
                    wr_d      = 1'b0;
                    cnt_d     = c_LOW_LOAD;
                    eng_d     = c_ENG_LOW;
                end
            end
            c_ENG_LOW: begin
                if (cnt_q == '0) begin
                    wr_d  = 1'b1;
                    cnt_d = c_HIGH_LOAD;
                    eng_d = c_ENG_HIGH;
                end else begin
                    cnt_d = cnt_q - c_CNT_ONE;
                end
            end
            c_ENG_HIGH: begin
                if (cnt_q == '0) begin
                    if (lo_pend_q) begin
                        // Pixel low byte follows back-to-back
                        data_d    = lo_byte_q;
                        lo_pend_d = 1'b0;
                        wr_d      = 1'b0;
                        cnt_d     = c_LOW_LOAD;
                        eng_d     = c_ENG_LOW;
                    end else begin
                        eng_d = c_ENG_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - c_CNT_ONE;
                end
            end
            default: begin
                wr_d  = 1'b1;
                eng_d = c_ENG_IDLE;
            end
        endcase
    end

    // Byte engine: registers (async reset drives WR high immediately)
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            eng_q     <= c_ENG_IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b1;
            rs_q      <= 1'b1;
            data_q    <= 8'h00;
            lo_byte_q <= 8'h00;
            lo_pend_q <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            eng_q     <= eng_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            rs_q      <= rs_d;
            data_q    <= data_d;
            lo_byte_q <= lo_byte_d;
            lo_pend_q <= lo_pend_d;
            last_q    <= last_d;
        end
    end

    assign o_lcd_wr   = wr_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_data = data_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_bus_arbiter
// Purpose  : Self-checking bench for lcd_bus_arbiter. Expected bus bytes
//            {RS,DATA} are queued as stimulus is issued and popped on every
//            rising WR edge seen on the panel side.
// Revision : 1.0  initial release
// ============================================================================
module tb_lcd_bus_arbiter;

    localparam int c_WR_LOW  = 2;
    localparam int c_WR_HIGH = 2;
    localparam int c_TIMEOUT = 1000;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [8:0]  i_cmd_data;
    logic        i_cmd_last;
    logic        i_pix_valid;
    logic        o_pix_ready;
    logic [15:0] i_pix_data;
    logic        i_pix_last;
    logic        i_lcd_fmark;
    logic [7:0]  o_lcd_data;
    logic        o_lcd_rs;
    logic        o_lcd_wr;
    logic        o_lcd_cs_n;
    logic [1:0]  o_owner;

    int n_chk  = 0;
    int n_pass = 0;
    int wr_falls = 0;
    int cs_falls = 0;
    int low_cnt  = 0;
    logic prev_wr = 1'b1;
    logic prev_cs = 1'b1;
    logic [8:0] q_exp[$];

    always #5 clk = ~clk;

    lcd_bus_arbiter #(
        .WR_LOW_CYC (c_WR_LOW),
        .WR_HIGH_CYC(c_WR_HIGH),
        .FMARK_SYNC (1)
    ) u_dut (
        .i_clk      (clk),
        .i_reset_n  (i_reset_n),
        .i_cmd_valid(i_cmd_valid),
        .o_cmd_ready(o_cmd_ready),
        .i_cmd_data (i_cmd_data),
        .i_cmd_last (i_cmd_last),
        .i_pix_valid(i_pix_valid),
        .o_pix_ready(o_pix_ready),
        .i_pix_data (i_pix_data),
        .i_pix_last (i_pix_last),
        .i_lcd_fmark(i_lcd_fmark),
        .o_lcd_data (o_lcd_data),
        .o_lcd_rs   (o_lcd_rs),
        .o_lcd_wr   (o_lcd_wr),
        .o_lcd_cs_n (o_lcd_cs_n),
        .o_owner    (o_owner)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Panel-side monitor: the panel latches on the WR rising edge
    always @(negedge clk) begin
        if (!i_reset_n) begin
            prev_wr = 1'b1;
            prev_cs = 1'b1;
            low_cnt = 0;
        end else begin
            if (prev_cs && !o_lcd_cs_n) cs_falls++;
            if (prev_wr && !o_lcd_wr) wr_falls++;
            if (!o_lcd_wr) low_cnt++;
            if (!prev_wr && o_lcd_wr) begin
                check("wr_low_len", low_cnt, c_WR_LOW);
                check("cs_during_wr", o_lcd_cs_n, 1'b0);
                check("byte_expected", (q_exp.size() != 0), 1'b1);
                if (q_exp.size() != 0) begin
                    check("bus_byte", {o_lcd_rs, o_lcd_data}, q_exp.pop_front());
                end
                low_cnt = 0;
            end
            prev_wr = o_lcd_wr;
            prev_cs = o_lcd_cs_n;
        end
    end

    task automatic send_cmd(input logic [8:0] d, input logic last);
        int n;
        @(posedge clk); #1;
        i_cmd_valid = 1'b1;
        i_cmd_data  = d;
        i_cmd_last  = last;
        n = 0;
        @(negedge clk);
        while (!o_cmd_ready && n < c_TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept_in_time", (n < c_TIMEOUT), 1'b1);
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
        i_cmd_last  = 1'b0;
    endtask

    task automatic send_pix(input logic [15:0] d, input logic last);
        int n;
        @(posedge clk); #1;
        i_pix_valid = 1'b1;
        i_pix_data  = d;
        i_pix_last  = last;
        n = 0;
        @(negedge clk);
        while (!o_pix_ready && n < c_TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check("pix_accept_in_time", (n < c_TIMEOUT), 1'b1);
        @(posedge clk); #1;
        i_pix_valid = 1'b0;
        i_pix_last  = 1'b0;
    endtask

    task automatic pulse_fmark(input int delay);
        repeat (delay) @(posedge clk);
        #1 i_lcd_fmark = 1'b1;
        repeat (4) @(posedge clk);
        #1 i_lcd_fmark = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (o_owner != 2'd0 && n < c_TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check(tag, o_owner, 2'd0);
        check({tag, "_cs"}, o_lcd_cs_n, 1'b1);
        check({tag, "_sb_empty"}, q_exp.size(), 0);
    endtask

    initial begin
        int cs0, wf0, bad_own, bad_cs, bad_rdy, n;
        logic [8:0] t2[5];
        i_reset_n   = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_data  = '0;
        i_cmd_last  = 1'b0;
        i_pix_valid = 1'b0;
        i_pix_data  = '0;
        i_pix_last  = 1'b0;
        i_lcd_fmark = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr", o_lcd_wr, 1'b1);
        check("rst_rs", o_lcd_rs, 1'b1);
        check("rst_data", o_lcd_data, 8'h00);
        check("rst_cs", o_lcd_cs_n, 1'b1);
        check("rst_cmd_ready", o_cmd_ready, 1'b0);
        check("rst_pix_ready", o_pix_ready, 1'b0);
        check("rst_owner", o_owner, 2'd0);
        i_reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1: single command byte
        cs0 = cs_falls;
        q_exp.push_back({1'b0, 8'h2C});
        send_cmd({1'b0, 8'h2C}, 1'b1);
        wait_idle("t1_idle");
        check("t1_cs_windows", cs_falls - cs0, 1);

        // 2: command plus four parameters in one CS window
        cs0 = cs_falls;
        wf0 = wr_falls;
        t2[0] = {1'b0, 8'h2A};
        t2[1] = {1'b1, 8'h00};
        t2[2] = {1'b1, 8'h00};
        t2[3] = {1'b1, 8'h00};
        t2[4] = {1'b1, 8'hEF};
        for (int i = 0; i < 5; i++) q_exp.push_back(t2[i]);
        for (int i = 0; i < 5; i++) send_cmd(t2[i], (i == 4));
        wait_idle("t2_idle");
        check("t2_cs_windows", cs_falls - cs0, 1);
        check("t2_wr_pulses", wr_falls - wf0, 5);

        // 3: pixel frame gated by FMARK
        wf0 = wr_falls;
        q_exp.push_back({1'b1, 8'hF8});
        q_exp.push_back({1'b1, 8'h00});
        fork
            send_pix(16'hF800, 1'b1);
            begin
                repeat (20) @(posedge clk);
                @(negedge clk);
                check("t3_owner_wait", o_owner, 2'd2);
                check("t3_cs_wait", o_lcd_cs_n, 1'b1);
                check("t3_no_wr_before_te", wr_falls - wf0, 0);
                pulse_fmark(0);
            end
        join
        wait_idle("t3_idle");

        // 4: simultaneous requests, command wins
        q_exp.push_back({1'b0, 8'h2C});
        q_exp.push_back({1'b1, 8'h12});
        q_exp.push_back({1'b1, 8'h34});
        fork
            send_cmd({1'b0, 8'h2C}, 1'b1);
            send_pix(16'h1234, 1'b1);
            begin
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                check("t4_owner_cmd", o_owner, 2'd1);
                pulse_fmark(30);
            end
        join
        wait_idle("t4_idle");

        // 5: FMARK held low, pixel must stay parked
        wf0 = wr_falls;
        bad_own = 0;
        bad_cs = 0;
        bad_rdy = 0;
        fork
            send_pix(16'hABCD, 1'b1);
            begin
                repeat (3) @(negedge clk);
                for (int i = 0; i < 500; i++) begin
                    @(negedge clk);
                    if (o_owner != 2'd2) bad_own++;
                    if (o_lcd_cs_n != 1'b1) bad_cs++;
                    if (o_pix_ready) bad_rdy++;
                end
                check("t5_owner_cycles_bad", bad_own, 0);
                check("t5_cs_cycles_bad", bad_cs, 0);
                check("t5_ready_cycles_bad", bad_rdy, 0);
                check("t5_no_wr", wr_falls - wf0, 0);
                pulse_fmark(0);
            end
        join

        // 6: reset during WR low of the first pixel byte
        n = 0;
        @(negedge clk);
        while (o_lcd_wr && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_wr_low_seen", o_lcd_wr, 1'b0);
        #2 i_reset_n = 1'b0;
        #1;
        check("t6_rst_wr", o_lcd_wr, 1'b1);
        check("t6_rst_cs", o_lcd_cs_n, 1'b1);
        check("t6_rst_owner", o_owner, 2'd0);
        check("t6_rst_pix_ready", o_pix_ready, 1'b0);
        q_exp.delete();
        repeat (3) @(posedge clk);
        #1 i_reset_n = 1'b1;
        q_exp.push_back({1'b0, 8'h29});
        send_cmd({1'b0, 8'h29}, 1'b1);
        wait_idle("t6_restart_idle");

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
